// File: rtl/rgu_pixel_scheduler.sv
// Raster-order pixel sequencer for the ray generation unit: loads X/Y, restarts, runs to stop bit.
// All outputs are registered; new pixels are held off while the downstream ray FIFO is almost full.
module rgu_pixel_scheduler #(
  parameter int COORD_W        = 16,
  parameter int REG_PIXEL_X    = 0,
  parameter int REG_PIXEL_Y    = 1,
  parameter int MAX_RUN_CYCLES = 64
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iStart,
  input  logic               iAbort,
  input  logic [COORD_W-1:0] iResX,
  input  logic [COORD_W-1:0] iResY,
  input  logic               iFifoAlmostFull,
  input  logic               iRguStop,
  input  logic               iRguFifoPush,
  output logic               oRguSelected,
  output logic               oRguWrite,
  output logic [7:0]         oRguAddr,
  output logic [31:0]        oRguData,
  output logic               oRguRestart,
  output logic               oRguEnable,
  output logic               oBusy,
  output logic               oDone,
  output logic               oError,
  output logic [COORD_W-1:0] oPixelX,
  output logic [COORD_W-1:0] oPixelY,
  output logic [7:0]         oPushCount
);

  typedef enum logic [2:0] {
    IDLE, WAIT_SPACE, LOAD_X, LOAD_Y, RESTART, RUN, ADVANCE, DONE
  } state_t;

  localparam int RUN_W = $clog2(MAX_RUN_CYCLES + 1);
  localparam logic [RUN_W-1:0]   RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0]   RUN_MAX  = RUN_W'(MAX_RUN_CYCLES);
  localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);

  state_t             state, stateNext;
  logic [COORD_W-1:0] resX, resY;
  logic [RUN_W-1:0]   runCount;
  logic               startOk, lastCol, lastRow, watchdogHit;
  logic               selNext, wrNext, restartNext, enableNext, busyNext, doneNext;
  logic [7:0]         addrNext;
  logic [31:0]        dataNext;

  assign startOk = iStart && (iResX != '0) && (iResY != '0);
  assign lastCol = (oPixelX == resX - COORD_ONE);
  assign lastRow = (oPixelY == resY - COORD_ONE);

  always_comb begin
    stateNext   = state;
    watchdogHit = 1'b0;
    case (state)
      IDLE:       if (startOk) stateNext = WAIT_SPACE;
      WAIT_SPACE: if (!iFifoAlmostFull) stateNext = LOAD_X;
      LOAD_X:     stateNext = LOAD_Y;
      LOAD_Y:     stateNext = RESTART;
      RESTART:    stateNext = RUN;
      RUN: begin
        // The stop bit seen in the first RUN cycle belongs to the previous program.
        if (runCount != RUN_ONE && iRguStop) begin
          stateNext = ADVANCE;
        end else if (runCount == RUN_MAX) begin
          stateNext   = DONE;
          watchdogHit = 1'b1;
        end
      end
      ADVANCE:    stateNext = (lastCol && lastRow) ? DONE : WAIT_SPACE;
      DONE:       stateNext = IDLE;
      default:    stateNext = IDLE;
    endcase
    if (iAbort && state != IDLE) begin
      stateNext   = IDLE;
      watchdogHit = 1'b0;
    end

    // Outputs are decoded from the next state so they register alongside it.
    selNext     = 1'b0;
    wrNext      = 1'b0;
    restartNext = 1'b0;
    enableNext  = 1'b0;
    doneNext    = 1'b0;
    addrNext    = '0;
    dataNext    = '0;
    busyNext    = (stateNext != IDLE) && (stateNext != DONE);
    case (stateNext)
      LOAD_X: begin
        selNext  = 1'b1;
        wrNext   = 1'b1;
        addrNext = {1'b0, 7'(REG_PIXEL_X)};
        dataNext = 32'(oPixelX);
      end
      LOAD_Y: begin
        selNext  = 1'b1;
        wrNext   = 1'b1;
        addrNext = {1'b0, 7'(REG_PIXEL_Y)};
        dataNext = 32'(oPixelY);
      end
      RESTART: restartNext = 1'b1;
      RUN:     enableNext  = 1'b1;
      DONE:    doneNext    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state        <= IDLE;
      resX         <= '0;
      resY         <= '0;
      runCount     <= '0;
      oRguSelected <= 1'b0;
      oRguWrite    <= 1'b0;
      oRguAddr     <= '0;
      oRguData     <= '0;
      oRguRestart  <= 1'b0;
      oRguEnable   <= 1'b0;
      oBusy        <= 1'b0;
      oDone        <= 1'b0;
      oError       <= 1'b0;
      oPixelX      <= '0;
      oPixelY      <= '0;
      oPushCount   <= '0;
    end else begin
      state        <= stateNext;
      oRguSelected <= selNext;
      oRguWrite    <= wrNext;
      oRguAddr     <= addrNext;
      oRguData     <= dataNext;
      oRguRestart  <= restartNext;
      oRguEnable   <= enableNext;
      oBusy        <= busyNext;
      oDone        <= doneNext;

      if (state == IDLE && startOk) begin
        resX    <= iResX;
        resY    <= iResY;
        oPixelX <= '0;
        oPixelY <= '0;
        oError  <= 1'b0;
      end
      if (watchdogHit) oError <= 1'b1;

      if (state == ADVANCE && !iAbort) begin
        if (!lastCol) begin
          oPixelX <= oPixelX + COORD_ONE;
        end else begin
          oPixelX <= '0;
          if (!lastRow) oPixelY <= oPixelY + COORD_ONE;
        end
      end

      if (stateNext == RUN) runCount <= (state == RUN) ? runCount + RUN_ONE : RUN_ONE;
      else                  runCount <= '0;

      if (stateNext == RESTART)
        oPushCount <= '0;
      else if (state == RUN && iRguFifoPush && oPushCount != 8'hFF)
        oPushCount <= oPushCount + 8'd1;
    end
  end

endmodule
